// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use / RAW hazard
// detection that freezes PC and IF/ID and injects bubbles into EX.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_btn,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  EX_MEM_Regrd,
    input  logic              EX_MEM_Regwrite,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [REG_W-1:0]  ID_EX_Regrs,
    output logic [REG_W-1:0]  ID_EX_Regrt,
    output logic [REG_W-1:0]  ID_EX_Regrd,
    output logic              ID_EX_Regwrite,
    output logic              ID_EX_Memread,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [DATA_W-1:0] ID_EX_rdata1,
    output logic [DATA_W-1:0] ID_EX_rdata2,
    output logic [DATA_W-1:0] ID_EX_imm,
    output logic              ID_EX_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic              bubble;
    } id_ex_t;

    // An all-zero bundle with the bubble flag set is both the reset value and a squashed slot.
    localparam id_ex_t BUBBLE = '{bubble: 1'b1, default: '0};

    id_ex_t           id_ex_q, id_ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [REG_W-1:0] id_dst;
    logic             load_use, raw_id_ex, raw_ex_mem, hazard, stall;

    // $0 is hardwired, so it can never create a dependency.
    function automatic logic src_match(input logic [REG_W-1:0] x);
        return (x != '0) && ((x == id_rs) || (id_uses_rt && (x == id_rt)));
    endfunction

    assign id_dst     = id_regdst ? id_rd : id_rt;
    assign load_use   = id_ex_q.memread && id_ex_q.regwrite && src_match(id_ex_q.rd);
    assign raw_id_ex  = id_ex_q.regwrite && src_match(id_ex_q.rd);
    assign raw_ex_mem = EX_MEM_Regwrite && src_match(EX_MEM_Regrd);
    assign hazard     = load_use || (!forward_btn && (raw_id_ex || raw_ex_mem));
    assign stall      = hazard && !flush;

    assign pc_write    = !stall;
    assign if_id_write = !stall;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        id_ex_d       = BUBBLE;
        stall_count_d = stall_count_q;
        if (!(flush || stall)) begin
            id_ex_d.rs       = id_rs;
            id_ex_d.rt       = id_rt;
            id_ex_d.rd       = id_dst;
            id_ex_d.regwrite = id_regwrite;
            id_ex_d.memread  = id_memread;
            id_ex_d.ctrl     = id_ctrl;
            id_ex_d.rdata1   = id_rdata1;
            id_ex_d.rdata2   = id_rdata2;
            id_ex_d.imm      = id_imm;
            id_ex_d.bubble   = 1'b0;
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q       <= BUBBLE;
            stall_count_q <= '0;
        end else begin
            id_ex_q       <= id_ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ID_EX_Regrs    = id_ex_q.rs;
    assign ID_EX_Regrt    = id_ex_q.rt;
    assign ID_EX_Regrd    = id_ex_q.rd;
    assign ID_EX_Regwrite = id_ex_q.regwrite;
    assign ID_EX_Memread  = id_ex_q.memread;
    assign ID_EX_ctrl     = id_ex_q.ctrl;
    assign ID_EX_rdata1   = id_ex_q.rdata1;
    assign ID_EX_rdata2   = id_ex_q.rdata2;
    assign ID_EX_imm      = id_ex_q.imm;
    assign ID_EX_bubble   = id_ex_q.bubble;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed hazard scenarios, randomized
// traffic against a behavioural model of the ID/EX slot, and stall-counter saturation.
module tb_id_ex_hazard_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 6;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, forward_btn, flush;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              id_uses_rt, id_regdst, id_regwrite, id_memread;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
    logic [REG_W-1:0]  EX_MEM_Regrd;
    logic              EX_MEM_Regwrite;
    logic              pc_write, if_id_write;
    logic [REG_W-1:0]  ID_EX_Regrs, ID_EX_Regrt, ID_EX_Regrd;
    logic              ID_EX_Regwrite, ID_EX_Memread, ID_EX_bubble;
    logic [CTRL_W-1:0] ID_EX_ctrl;
    logic [DATA_W-1:0] ID_EX_rdata1, ID_EX_rdata2, ID_EX_imm;
    logic [CNT_W-1:0]  stall_count;

    always #5 clk = ~clk;

    id_ex_hazard_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .forward_btn(forward_btn), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .EX_MEM_Regrd(EX_MEM_Regrd), .EX_MEM_Regwrite(EX_MEM_Regwrite),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .ID_EX_Regrs(ID_EX_Regrs), .ID_EX_Regrt(ID_EX_Regrt), .ID_EX_Regrd(ID_EX_Regrd),
        .ID_EX_Regwrite(ID_EX_Regwrite), .ID_EX_Memread(ID_EX_Memread), .ID_EX_ctrl(ID_EX_ctrl),
        .ID_EX_rdata1(ID_EX_rdata1), .ID_EX_rdata2(ID_EX_rdata2), .ID_EX_imm(ID_EX_imm),
        .ID_EX_bubble(ID_EX_bubble), .stall_count(stall_count)
    );

    // Reference view of what instruction occupies EX (or a bubble), plus the stall tally.
    typedef struct {
        int unsigned rs, rt, rd;
        bit          regwrite, memread, bubble;
        int unsigned ctrl;
        logic [DATA_W-1:0] rd1, rd2, imm;
    } slot_t;

    slot_t       m;
    int unsigned m_cnt;
    int          checks = 0;
    int          failures = 0;
    bit          auto_exmem = 1'b1;
    logic        seen_pc_write;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{rs: 0, rt: 0, rd: 0, regwrite: 0, memread: 0, bubble: 1, ctrl: 0,
              rd1: '0, rd2: '0, imm: '0};
        return s;
    endfunction

    // Does the decoding instruction read register x?
    function automatic bit reads(input int unsigned x);
        return (x != 0) && (x == id_rs || (id_uses_rt && x == id_rt));
    endfunction

    function automatic bit model_stall();
        bit haz;
        haz = m.memread && m.regwrite && reads(m.rd);
        if (!forward_btn)
            haz = haz || (m.regwrite && reads(m.rd)) || (EX_MEM_Regwrite && reads(EX_MEM_Regrd));
        return haz && !flush;
    endfunction

    task automatic set_instr(input int rs, input int rt, input int rd, input bit uses_rt,
                             input bit regdst, input bit regwrite, input bit memread);
        id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_rd = REG_W'(rd);
        id_uses_rt = uses_rt; id_regdst = regdst; id_regwrite = regwrite; id_memread = memread;
        id_ctrl   = CTRL_W'($urandom);
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    endtask

    // One clock: check the combinational stall, advance the model, check the new ID/EX slot.
    task automatic step();
        bit    st;
        slot_t prev, nxt;
        #1;
        st = model_stall();
        seen_pc_write = pc_write;
        check("pc_write", 64'(pc_write), 64'(!st));
        check("if_id_write", 64'(if_id_write), 64'(!st));
        prev = m;
        if (rst) begin
            nxt = empty_slot();
        end else if (flush || st) begin
            nxt = empty_slot();
        end else begin
            nxt = '{rs: id_rs, rt: id_rt, rd: (id_regdst ? id_rd : id_rt),
                    regwrite: id_regwrite, memread: id_memread, bubble: 0, ctrl: id_ctrl,
                    rd1: id_rdata1, rd2: id_rdata2, imm: id_imm};
        end
        if (rst) m_cnt = 0;
        else if (st && m_cnt < CNT_MAX) m_cnt++;
        @(posedge clk);
        #1;
        m = nxt;
        if (auto_exmem) begin
            EX_MEM_Regrd    = rst ? '0 : REG_W'(prev.rd);
            EX_MEM_Regwrite = rst ? 1'b0 : prev.regwrite;
        end
        check("Regrs", 64'(ID_EX_Regrs), 64'(m.rs));
        check("Regrt", 64'(ID_EX_Regrt), 64'(m.rt));
        check("Regrd", 64'(ID_EX_Regrd), 64'(m.rd));
        check("Regwrite", 64'(ID_EX_Regwrite), 64'(m.regwrite));
        check("Memread", 64'(ID_EX_Memread), 64'(m.memread));
        check("ctrl", 64'(ID_EX_ctrl), 64'(m.ctrl));
        check("rdata1", 64'(ID_EX_rdata1), 64'(m.rd1));
        check("rdata2", 64'(ID_EX_rdata2), 64'(m.rd2));
        check("imm", 64'(ID_EX_imm), 64'(m.imm));
        check("bubble", 64'(ID_EX_bubble), 64'(m.bubble));
        check("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned base;
        m = empty_slot(); m_cnt = 0;
        rst = 1'b1; forward_btn = 1'b1; flush = 1'b0;
        EX_MEM_Regrd = '0; EX_MEM_Regwrite = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset state
        do_reset();
        check("rst_bubble", 64'(ID_EX_bubble), 64'd1);
        check("rst_regwrite", 64'(ID_EX_Regwrite), 64'd0);
        check("rst_count", 64'(stall_count), 64'd0);
        #1 check("rst_pc_write", 64'(pc_write), 64'd1);

        // Load-use with forwarding: lw $8 then add $9,$8,$2 costs one bubble
        forward_btn = 1'b1;
        set_instr(1, 8, 0, 0, 0, 1, 1); step();
        set_instr(8, 2, 9, 1, 1, 1, 0); step();
        check("lu_pc_write", 64'(seen_pc_write), 64'd0);
        check("lu_bubble", 64'(ID_EX_bubble), 64'd1);
        step();
        check("lu_retry_pc", 64'(seen_pc_write), 64'd1);
        check("lu_add_rd", 64'(ID_EX_Regrd), 64'd9);
        check("lu_count", 64'(stall_count), 64'd1);

        // Forwarding off: add $8,$1,$2 then sub $3,$8,$4 costs two bubbles
        do_reset();
        forward_btn = 1'b0;
        set_instr(1, 2, 8, 1, 1, 1, 0); step();
        set_instr(8, 4, 3, 1, 1, 1, 0); step(); step(); step();
        check("raw_count", 64'(stall_count), 64'd2);
        check("raw_sub_rd", 64'(ID_EX_Regrd), 64'd3);
        // Same pair with forwarding on: no stalls
        forward_btn = 1'b1;
        set_instr(1, 2, 8, 1, 1, 1, 0); step();
        set_instr(8, 4, 3, 1, 1, 1, 0); step();
        check("fwd_nostall", 64'(seen_pc_write), 64'd1);
        check("fwd_count", 64'(stall_count), 64'd2);

        // Destination $0 is never a hazard
        do_reset();
        forward_btn = 1'b0;
        set_instr(1, 2, 0, 1, 1, 1, 0); step();
        set_instr(0, 0, 3, 1, 1, 1, 0); step(); step();
        check("r0_count", 64'(stall_count), 64'd0);

        // lw $8 then addi $9,$10,8: rt only matters when it is a source
        do_reset();
        forward_btn = 1'b1;
        set_instr(1, 8, 0, 0, 0, 1, 1); step();
        set_instr(10, 8, 0, 0, 0, 1, 0); step();
        check("addi_nostall", 64'(seen_pc_write), 64'd1);
        set_instr(1, 8, 0, 0, 0, 1, 1); step();
        set_instr(10, 8, 9, 1, 1, 1, 0); step();
        check("uses_rt_stall", 64'(seen_pc_write), 64'd0);
        check("uses_rt_count", 64'(stall_count), 64'd1);
        step();

        // Flush during a load-use hazard wins: no stall, bubble, count unchanged
        set_instr(1, 8, 0, 0, 0, 1, 1); step();
        set_instr(8, 2, 9, 1, 1, 1, 0); flush = 1'b1; step();
        flush = 1'b0;
        check("flush_pc_write", 64'(seen_pc_write), 64'd1);
        check("flush_bubble", 64'(ID_EX_bubble), 64'd1);
        check("flush_count", 64'(stall_count), 64'd1);

        // Reset mid-stall releases PC next cycle
        set_instr(1, 8, 0, 0, 0, 1, 1); step();
        set_instr(8, 2, 9, 1, 1, 1, 0); rst = 1'b1; step();
        rst = 1'b0; step();
        check("rst_midstall_pc", 64'(seen_pc_write), 64'd1);

        // Randomized traffic; small register range keeps dependencies frequent
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            forward_btn = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            auto_exmem  = ($urandom_range(0, 4) != 0);
            if (!auto_exmem) begin
                EX_MEM_Regrd    = REG_W'($urandom_range(0, 3));
                EX_MEM_Regwrite = $urandom_range(0, 1);
            end
            set_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1));
            step();
        end
        rst = 1'b0; flush = 1'b0; auto_exmem = 1'b1;

        // Saturation: a persistent EX/MEM dependency with forwarding off stalls every cycle
        do_reset();
        auto_exmem = 1'b0;
        forward_btn = 1'b0;
        EX_MEM_Regrd = REG_W'(8); EX_MEM_Regwrite = 1'b1;
        set_instr(8, 0, 0, 0, 0, 0, 0);
        base = m_cnt;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        check("sat_count", 64'(stall_count), 64'(CNT_MAX));
        check("sat_pc_write", 64'(pc_write), 64'd0);
        m = empty_slot();
        m_cnt = (base + 65540 > CNT_MAX) ? CNT_MAX : base + 65540;
        step();
        check("sat_hold", 64'(stall_count), 64'hFFFF);
        auto_exmem = 1'b1;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated hazard detection and bubble insertion for the 5-stage MIPS pipeline.
- Captures decoded operands and control from the decode stage.
- Drives ID_EX_Regrs/ID_EX_Regrt/ID_EX_Regrd/ID_EX_Regwrite directly into the forwarding unit downstream.
- Stalls PC and IF/ID on load-use hazards; when forwarding is disabled, also stalls on any in-flight RAW hazard.

Parameters:
DATA_W, 32, operand/immediate width
REG_W, 5, register specifier width
CTRL_W, 6, opaque pass-through control bundle (memwrite, memtoreg, alusrc, aluop[1:0], branch)
CNT_W, 16, stall-statistics counter width

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  synchronous active-high reset
forward_btn  input  1  1 = forwarding enabled, 0 = forwarding disabled (stall-only mode)
flush  input  1  branch-taken flush from EX; kill instruction entering ID/EX
id_rs  input  REG_W  decode-stage rs
id_rt  input  REG_W  decode-stage rt
id_rd  input  REG_W  decode-stage rd
id_uses_rt  input  1  instruction reads rt as a source (R-type, sw, beq)
id_regdst  input  1  1 = dest is rd, 0 = dest is rt
id_regwrite  input  1  decode regwrite
id_memread  input  1  decode memread (load)
id_ctrl  input  CTRL_W  other decoded control
id_rdata1  input  DATA_W  register file read port 1
id_rdata2  input  DATA_W  register file read port 2
id_imm  input  DATA_W  sign-extended immediate
EX_MEM_Regrd  input  REG_W  EX/MEM destination
EX_MEM_Regwrite  input  1  EX/MEM regwrite
pc_write  output  1  0 freezes PC
if_id_write  output  1  0 freezes IF/ID register
ID_EX_Regrs  output  REG_W  registered rs
ID_EX_Regrt  output  REG_W  registered rt
ID_EX_Regrd  output  REG_W  registered resolved destination
ID_EX_Regwrite  output  1  registered regwrite
ID_EX_Memread  output  1  registered memread
ID_EX_ctrl  output  CTRL_W  registered control bundle
ID_EX_rdata1  output  DATA_W  registered operand 1
ID_EX_rdata2  output  DATA_W  registered operand 2
ID_EX_imm  output  DATA_W  registered immediate
ID_EX_bubble  output  1  1 = current ID/EX content is an inserted bubble
stall_count  output  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Dest resolve: dst = id_regdst ? id_rd : id_rt. Register 0 is never a hazard source or target.
- Source match m(X) = (X != 0) && (X == id_rs || (id_uses_rt && X == id_rt)).
- Load-use hazard (both modes): ID_EX_Memread && ID_EX_Regwrite && m(ID_EX_Regrd).
- Forwarding off (forward_btn=0), additionally:
  - ID_EX_Regwrite && m(ID_EX_Regrd), or
  - EX_MEM_Regwrite && m(EX_MEM_Regrd).
  - MEM/WB is never a hazard: the register file is write-first.
- stall = hazard && !flush. Combinational outputs: pc_write = if_id_write = !stall.
- Register update priority per rising edge:
  - rst: all ID_EX_* fields 0, ID_EX_bubble=1, stall_count=0.
  - else flush or stall: bubble. ID_EX_Regwrite=0, ID_EX_Memread=0, ID_EX_ctrl=0, ID_EX_Regrd=0, ID_EX_bubble=1; Regrs/Regrt/data fields also 0.
  - else: capture all id_* fields (Regrd=dst), ID_EX_bubble=0.
- Latency: 1 cycle decode->ID/EX. Load-use costs exactly 1 bubble. Forwarding-off RAW costs 2 bubbles if the producer is directly ahead, 1 if two ahead.
- stall_count increments by 1 on each cycle with stall=1; saturates at all-ones; not incremented by flush.
- forward_btn may change any cycle; the hazard decision uses the current-cycle value.
- flush and hazard in the same cycle: flush wins, pc_write=1, no count.
- rst mid-stall: next cycle pc_write=1 (ID/EX holds a bubble, so no hazard).
- Bubble-only pipeline never raises stall.

Test Plan:
- Reset -> ID_EX_bubble=1, ID_EX_Regwrite=0, stall_count=0, pc_write=1.
- forward_btn=1, lw $8 then add $9,$8,$2 -> one cycle pc_write=0, bubble captured, add captured next cycle, stall_count=1.
- forward_btn=0, add $8,$1,$2 then sub $3,$8,$4 -> two stall cycles (ID/EX match, then EX/MEM match), stall_count=2; with forward_btn=1 -> zero stalls.
- Dest $0 (add $0,$1,$2 then add $3,$0,$0, forward_btn=0) -> no stall.
- lw $8 followed by addi $9,$10,8 (id_uses_rt=0, id_rt=8) -> no stall; same with id_uses_rt=1 -> 1 stall.
- flush asserted during a load-use hazard -> pc_write=1, bubble, stall_count unchanged; hold stall 65540 cycles (CNT_W=16) -> stall_count=16'hFFFF.
